// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage: PC register, IF/ID pipeline register, redirect/flush/stall handling
// Priority in RUN is redirect > flush > stall; a bubble is valid=0 with a NOP instruction word.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // Natural 32-bit wrap gives FFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_id_valid_d    = if_id_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_inst_d     = if_id_inst_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    addr_err_d       = 1'b0;
    fetch_count_d    = fetch_count_q;

    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d          = {redirect_pc[31:2], 2'b00};
          if_id_valid_d = 1'b0;
          if_id_inst_d  = 32'h0000_0000;
          addr_err_d    = |redirect_pc[1:0];
        end else if (flush) begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = 32'h0000_0000;
          if (!stall) pc_d = pc_plus4;
        end else if (!stall) begin
          pc_d             = pc_plus4;
          if_id_valid_d    = 1'b1;
          if_id_pc_d       = pc_q;
          if_id_inst_d     = inst_data;
          if_id_pc_plus4_d = pc_plus4;
          fetch_count_d    = fetch_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      if_id_valid_q    <= 1'b0;
      if_id_pc_q       <= 32'h0000_0000;
      if_id_inst_q     <= 32'h0000_0000;
      if_id_pc_plus4_q <= 32'h0000_0000;
      addr_err_q       <= 1'b0;
      fetch_count_q    <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_inst_q     <= if_id_inst_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      addr_err_q       <= addr_err_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign inst_ce        = (state_q == RUN);
  assign inst_addr      = pc_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_inst     = if_id_inst_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign addr_err       = addr_err_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - testbench for pc_fetch_unit
// Vector table of per-cycle controls and hand-derived post-edge outputs, queued through a scoreboard.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ce;
  logic [31:0] inst_addr, inst_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_inst, if_id_pc_plus4;
  logic        addr_err;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h3408_00FF : (a ^ 32'hDEAD_0000);
  endfunction

  assign inst_data = mem(inst_addr);

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ce        (inst_ce),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .addr_err       (addr_err),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] ifpc;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic valid, input logic [31:0] inst,
                              input logic [31:0] ifpc, input logic err, input logic [31:0] cnt);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
    v.addr = addr; v.valid = valid; v.inst = inst; v.ifpc = ifpc; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    stall = v.stall; flush = v.flush; redirect_valid = v.rv; redirect_pc = v.rpc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d inst_ce", idx), {31'b0, inst_ce}, 32'd1);
    chk($sformatf("v%0d inst_addr", idx), inst_addr, e.addr);
    chk($sformatf("v%0d if_id_valid", idx), {31'b0, if_id_valid}, {31'b0, e.valid});
    chk($sformatf("v%0d if_id_inst", idx), if_id_inst, e.inst);
    chk($sformatf("v%0d addr_err", idx), {31'b0, addr_err}, {31'b0, e.err});
    chk($sformatf("v%0d fetch_count", idx), fetch_count, e.cnt);
    if (e.valid) begin
      chk($sformatf("v%0d if_id_pc", idx), if_id_pc, e.ifpc);
      chk($sformatf("v%0d if_id_pc_plus4", idx), if_id_pc_plus4, e.ifpc + 32'd4);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " inst_ce"}, {31'b0, inst_ce}, 32'd0);
    chk({tag, " inst_addr"}, inst_addr, 32'h0);
    chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, 32'd0);
    chk({tag, " if_id_inst"}, if_id_inst, 32'h0);
    chk({tag, " if_id_pc"}, if_id_pc, 32'h0);
    chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, 32'h0);
    chk({tag, " addr_err"}, {31'b0, addr_err}, 32'd0);
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    // stall flush rv rpc | addr valid inst ifpc err cnt (outputs after the edge)
    vecs.push_back(mk(1, 1, 1, 32'h40,       32'h0,        0, 32'h0,             32'h0,        0, 0)); // idle ignores controls
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        1, 32'h3408_00FF,     32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        1, mem(32'h4),        32'h4,        0, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,        1, mem(32'h4),        32'h4,        0, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,        1, mem(32'h4),        32'h4,        0, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,        1, mem(32'h4),        32'h4,        0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'hC,        1, mem(32'h8),        32'h8,        0, 3));
    vecs.push_back(mk(1, 0, 1, 32'h10,       32'h10,       0, 32'h0,             32'h0,        0, 3)); // redirect beats stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h14,       1, mem(32'h10),       32'h10,       0, 4));
    vecs.push_back(mk(0, 1, 0, 32'h0,        32'h18,       0, 32'h0,             32'h0,        0, 4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        32'h18,       0, 32'h0,             32'h0,        0, 4)); // flush+stall holds pc
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h1C,       1, mem(32'h18),       32'h18,       0, 5));
    vecs.push_back(mk(0, 0, 1, 32'h13,       32'h10,       0, 32'h0,             32'h0,        1, 5)); // misaligned target
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h14,       1, mem(32'h10),       32'h10,       0, 6));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,           32'h0,        0, 6));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 7)); // pc wraps
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        1, 32'h3408_00FF,     32'h0,        0, 8));
    vecs.push_back(mk(0, 1, 1, 32'h21,       32'h20,       0, 32'h0,             32'h0,        1, 8));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h20,       0, 32'h0,             32'h0,        0, 8));

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    #1;
    chk("pre-run inst_ce", {31'b0, inst_ce}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted mid-stall with a valid instruction held.
    apply(mk(0, 0, 0, 32'h0, 32'h24, 1, mem(32'h20), 32'h20, 0, 9), 100);
    apply(mk(1, 0, 0, 32'h0, 32'h24, 1, mem(32'h20), 32'h20, 0, 9), 101);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("restart inst_ce", {31'b0, inst_ce}, 32'd0);
    apply(mk(0, 0, 0, 32'h0, 32'h0, 0, 32'h0,         32'h0, 0, 0), 102);
    apply(mk(0, 0, 0, 32'h0, 32'h4, 1, 32'h3408_00FF, 32'h0, 0, 1), 103);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-005 SHALL have port flush  input  1  squash IF/ID contents to a bubble.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target byte address.
REQ-008 SHALL have port inst_ce  output  1  instruction memory enable.
REQ-009 SHALL have port inst_addr  output  32  instruction memory byte address.
REQ-010 SHALL have port inst_data  input  32  instruction word returned combinationally by memory.
REQ-011 SHALL have port if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 SHALL have port if_id_pc  output  32  address of the held instruction.
REQ-013 SHALL have port if_id_inst  output  32  held instruction word.
REQ-014 SHALL have port if_id_pc_plus4  output  32  if_id_pc + 4, the link value for JAL.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse when redirect_pc[1:0] != 2'b00.
REQ-016 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-017 SHALL implement states IDLE and RUN; IDLE -> RUN on the first rising edge after rst_n deasserts; RUN has no exit except reset.
REQ-018 SHALL drive inst_ce = 1 only in RUN; inst_addr = PC register at all times (combinational).
REQ-019 SHALL, in IDLE, hold PC at RESET_PC and keep if_id_valid = 0.
REQ-020 SHALL, in RUN with no stall, flush or redirect, capture {PC, inst_data, PC+4} into IF/ID, set if_id_valid = 1 and advance PC by 4 on the same edge (one-cycle fetch latency).
REQ-021 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 SHALL, on redirect_valid, load PC with {redirect_pc[31:2], 2'b00} and write a bubble into IF/ID.
REQ-023 SHALL pulse addr_err for exactly one cycle, on the edge after a redirect with redirect_pc[1:0] != 0; the redirect still executes with the low bits cleared.
REQ-024 SHALL, on stall alone, hold PC and all IF/ID fields unchanged.
REQ-025 SHALL, on flush, write a bubble into IF/ID; PC advances by 4 unless stall is also set, in which case PC holds.
REQ-026 SHALL define a bubble as if_id_valid = 0 and if_id_inst = 32'h0000_0000 (NOP); if_id_pc and if_id_pc_plus4 are don't-care.
REQ-027 SHALL apply priority redirect > flush > stall: redirect with stall loads the redirect target and writes a bubble; flush with stall writes a bubble and holds PC.
REQ-028 SHALL increment fetch_count only on edges where IF/ID captures a real instruction (REQ-020); the count wraps from 32'hFFFF_FFFF to 0.
REQ-029 SHALL ignore stall, flush and redirect_valid while in IDLE.

Reset
REQ-030 SHALL, when rst_n = 0, immediately and asynchronously set state = IDLE, PC = RESET_PC, inst_ce = 0, if_id_valid = 0, if_id_inst = 0, if_id_pc = 0, if_id_pc_plus4 = 0, addr_err = 0 and fetch_count = 0, including when reset is asserted in the middle of a stall or redirect.
REQ-031 SHALL resume per REQ-017 after rst_n deasserts, with no stale IF/ID contents left visible.

Verification
REQ-032 Release reset; memory returns 32'h340800FF at address 0 -> one cycle with inst_ce = 0, then inst_addr = 0, then if_id_inst = 32'h340800FF, if_id_pc = 0, if_id_pc_plus4 = 4, inst_addr = 4.
REQ-033 Hold stall for 3 cycles at PC = 8 -> inst_addr stays 8, IF/ID unchanged, fetch_count unchanged; fetch resumes at 8 after stall drops.
REQ-034 Assert redirect_valid = 1 with redirect_pc = 32'h10 and stall = 1 in the same cycle -> next inst_addr = 32'h10, if_id_valid = 0, if_id_inst = 0.
REQ-035 Redirect with redirect_pc = 32'h13 -> inst_addr = 32'h10 and addr_err high for exactly one cycle.
REQ-036 Redirect to 32'hFFFF_FFFC, then run 2 cycles -> inst_addr sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 Pull rst_n low mid-stall with if_id_valid = 1 -> all outputs reach reset values without a clock edge; after release, fetch restarts at RESET_PC.
